posit_special_ctrl: RTL and testbench

//  Parametrised special-case controller for the posit multiplier pipeline. Classifies

---
 rtl/posit_special_ctrl_if.sv | 22 ++
 rtl/posit_special_ctrl.sv | 153 +++++++++++++++
 tb/tb_posit_special_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/posit_special_ctrl_if.sv
// Encoder request handshake between the posit special-case controller
// and the posit encoder.
interface posit_special_ctrl_if;
  logic       enc_ready;
  logic       enc_start;
  logic [1:0] enc_code;
  logic       enc_done;

  modport master (
    input  enc_ready,
    input  enc_done,
    output enc_start,
    output enc_code
  );

  modport slave (
    output enc_ready,
    output enc_done,
    input  enc_start,
    input  enc_code
  );
endinterface

// File: rtl/posit_special_ctrl.sv
// Posit multiplier special-case controller: queues zero/NaR events and
// issues encoder requests, flushing downstream stages while one is open.
module posit_special_ctrl #(
  parameter int              NSTG       = 2,
  parameter logic [NSTG-1:0] FLUSH_MASK = '1,
  parameter int              DEPTH      = 4,
  parameter int              TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       zero_a,
  input  logic                       nar_a,
  input  logic                       zero_b,
  input  logic                       nar_b,
  input  logic                       s2_valid,
  input  logic                       zero_exp,
  input  logic                       nar_exp,
  output logic                       in_ready,
  posit_special_ctrl_if.master       enc,
  output logic [NSTG-1:0]            stg_rst_n,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  input  logic                       err_clr,
  output logic                       ovf_err,
  output logic                       tmo_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   tmo_cnt;

  logic [1:0]      s1_code;
  logic [1:0]      s2_code;
  logic            pop;
  logic [CW-1:0]   space;
  logic            push1;
  logic            push2;
  logic            drop;
  logic            tmo_hit;
  logic [AW-1:0]   w1_ptr;
  logic [AW-1:0]   wr_next;

  function automatic logic [1:0] classify(
    input logic v,
    input logic nar,
    input logic zero
  );
    logic [1:0] c;
    c = 2'b00;
    if (v & nar)
      c = 2'b10;
    else if (v & zero)
      c = 2'b01;
    return c;
  endfunction

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    s1_code = classify(in_valid, nar_a | nar_b, zero_a | zero_b);
    s2_code = classify(s2_valid, nar_exp, zero_exp);
    pop     = (state == ISSUE);
    // a same-cycle pop frees its slot for this cycle's pushes
    space   = CW'(DEPTH) - count + CW'(pop);
    push2   = (|s2_code) && (space != '0);
    push1   = (|s1_code) && (space > CW'(push2));
    drop    = ((|s2_code) & ~push2) | ((|s1_code) & ~push1);
    w1_ptr  = push2 ? inc(wr_ptr) : wr_ptr;
    wr_next = push1 ? inc(w1_ptr) : w1_ptr;
    tmo_hit = (state == WAIT) && !enc.enc_done &&
              ((tmo_cnt + TW'(1)) == TW'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (push2)
      mem[wr_ptr] <= s2_code;
    if (push1)
      mem[w1_ptr] <= s1_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tmo_cnt <= '0;
      ovf_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      count  <= count + CW'(push2) + CW'(push1) - CW'(pop);
      if (pop)
        rd_ptr <= inc(rd_ptr);

      unique case (state)
        IDLE: begin
          if (count != '0 && enc.enc_ready)
            state <= ISSUE;
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (enc.enc_done || tmo_hit)
            state <= DONE;
        end
        DONE: begin
          tmo_cnt <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (drop)
        ovf_err <= 1'b1;
      else if (err_clr)
        ovf_err <= 1'b0;

      if (tmo_hit)
        tmo_err <= 1'b1;
      else if (err_clr)
        tmo_err <= 1'b0;
    end
  end

  assign enc.enc_start = (state == ISSUE);
  assign enc.enc_code  = pop ? mem[rd_ptr] : 2'b00;
  assign stg_rst_n     = (state == WAIT) ? ~FLUSH_MASK : '1;
  assign busy          = (state != IDLE) || (count != '0);
  assign in_ready      = (count <= CW'(DEPTH-2));
  assign fifo_count    = count;

endmodule

// File: tb/tb_posit_special_ctrl.sv
// Randomised and directed bench for posit_special_ctrl against a
// queue-based transaction model.
module tb_posit_special_ctrl;

  localparam int         NSTG    = 2;
  localparam int         DEPTH   = 4;
  localparam int         TIMEOUT = 15;
  localparam logic [1:0] MASK    = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, zero_a, nar_a, zero_b, nar_b;
  logic       s2_valid, zero_exp, nar_exp;
  logic       err_clr;
  logic       in_ready, busy, ovf_err, tmo_err;
  logic [1:0] stg_rst_n;
  logic [2:0] fifo_count;

  posit_special_ctrl_if enc();

  posit_special_ctrl #(
    .NSTG       (NSTG),
    .FLUSH_MASK (MASK),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .zero_a     (zero_a),
    .nar_a      (nar_a),
    .zero_b     (zero_b),
    .nar_b      (nar_b),
    .s2_valid   (s2_valid),
    .zero_exp   (zero_exp),
    .nar_exp    (nar_exp),
    .in_ready   (in_ready),
    .enc        (enc),
    .stg_rst_n  (stg_rst_n),
    .busy       (busy),
    .fifo_count (fifo_count),
    .err_clr    (err_clr),
    .ovf_err    (ovf_err),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int starts = 0;

  // model: pending codes, request phase (0 idle,1 issue,2 wait,3 done)
  int q[$];
  int ph = 0;
  int w = 0;
  bit m_ovf = 0;
  bit m_tmo = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    in_valid = 0; zero_a = 0; nar_a = 0; zero_b = 0; nar_b = 0;
    s2_valid = 0; zero_exp = 0; nar_exp = 0; err_clr = 0;
  endtask

  function automatic int code_of(input bit v, input bit nar, input bit zero);
    if (v && nar) return 2;
    if (v && zero) return 1;
    return 0;
  endfunction

  task automatic model_step();
    int sz0;
    int c1;
    int c2;
    bit drop;
    bit tset;
    sz0  = q.size();
    drop = 0;
    tset = 0;
    c1 = code_of(in_valid, nar_a || nar_b, zero_a || zero_b);
    c2 = code_of(s2_valid, nar_exp, zero_exp);
    if (ph == 1) void'(q.pop_front());
    if (c2 != 0) begin
      if (q.size() < DEPTH) q.push_back(c2); else drop = 1;
    end
    if (c1 != 0) begin
      if (q.size() < DEPTH) q.push_back(c1); else drop = 1;
    end
    case (ph)
      0: if (sz0 > 0 && enc.enc_ready) ph = 1;
      1: begin ph = 2; w = 0; end
      2: begin
        w++;
        if (enc.enc_done) ph = 3;
        else if (w == TIMEOUT) begin tset = 1; ph = 3; end
      end
      default: begin w = 0; ph = 0; end
    endcase
    if (drop) m_ovf = 1; else if (err_clr) m_ovf = 0;
    if (tset) m_tmo = 1; else if (err_clr) m_tmo = 0;
  endtask

  task automatic tick();
    logic [1:0] e_code;
    logic [1:0] e_stg;
    #1;
    if (!rst_n) begin
      q.delete(); ph = 0; w = 0; m_ovf = 0; m_tmo = 0;
    end
    e_code = (ph == 1) ? 2'(q[0]) : 2'b00;
    e_stg  = (ph == 2) ? ~MASK : 2'b11;
    if (enc.enc_start === 1'b1) starts++;
    chk("enc_start", enc.enc_start, ph == 1);
    chk("enc_code", enc.enc_code, e_code);
    chk("stg_rst_n", stg_rst_n, e_stg);
    chk("busy", busy, (ph != 0) || (q.size() != 0));
    chk("in_ready", in_ready, q.size() <= DEPTH - 2);
    chk("fifo_count", fifo_count, q.size());
    chk("ovf_err", ovf_err, m_ovf);
    chk("tmo_err", tmo_err, m_tmo);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    enc.enc_ready = 1;
    enc.enc_done  = 0;
    @(negedge clk);
    tick();
    rst_n = 1;

    // single NaR on operand A
    in_valid = 1; nar_a = 1; tick(); clr_in();
    repeat (6) tick();
    enc.enc_done = 1; tick(); enc.enc_done = 0;
    repeat (3) tick();
    chk("t1_starts", starts, 1);

    // NaR priority in stage 1, zero from stage 2
    in_valid = 1; zero_b = 1; nar_a = 1; tick(); clr_in();
    s2_valid = 1; zero_exp = 1; tick(); clr_in();
    enc.enc_done = 1; repeat (12) tick();

    // simultaneous stage-1 and stage-2 events
    in_valid = 1; zero_a = 1; s2_valid = 1; nar_exp = 1; tick(); clr_in();
    repeat (12) tick();

    // overflow with encoder stalled
    enc.enc_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; zero_a = 1; tick();
    end
    clr_in(); tick();
    err_clr = 1; tick(); err_clr = 0;
    enc.enc_ready = 1;
    repeat (30) tick();

    // timeout with done withheld, then done on the final wait cycle
    enc.enc_done = 0;
    in_valid = 1; nar_b = 1; tick(); clr_in();
    repeat (20) tick();
    err_clr = 1; tick(); err_clr = 0;
    in_valid = 1; zero_b = 1; tick(); clr_in();
    for (int i = 0; i < 25; i++) begin
      enc.enc_done = (ph == 2 && w == TIMEOUT - 1);
      tick();
    end
    enc.enc_done = 0;

    // reset during WAIT with events still queued
    in_valid = 1; nar_a = 1; s2_valid = 1; zero_exp = 1; tick(); clr_in();
    repeat (4) tick();
    rst_n = 0; tick(); tick();
    rst_n = 1; repeat (5) tick();

    for (int i = 0; i < 3000; i++) begin
      in_valid      = ($urandom_range(0, 99) < 40);
      zero_a        = $urandom_range(0, 1);
      nar_a         = ($urandom_range(0, 99) < 20);
      zero_b        = $urandom_range(0, 1);
      nar_b         = ($urandom_range(0, 99) < 20);
      s2_valid      = ($urandom_range(0, 99) < 30);
      zero_exp      = $urandom_range(0, 1);
      nar_exp       = ($urandom_range(0, 99) < 30);
      err_clr       = ($urandom_range(0, 99) < 5);
      enc.enc_ready = ($urandom_range(0, 99) < 80);
      enc.enc_done  = ($urandom_range(0, 99) < 15);
      rst_n         = ($urandom_range(0, 999) >= 4);
      tick();
    end
    rst_n = 1;
    clr_in();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
